// File: rtl/sum_decoder.sv
// sum_decoder: recovers operand B from an adder result (sum = A + B) by
// subtracting A from the sum one bit per clock, LSB first, with a ripple
// borrow. Valid/ready handshake on both the input pair and the result.
// Optional error flag is enabled by defining SUM_DEC_ERR_EN; without it
// out_err is tied low and no error logic is built.
module sum_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  // Operand shift registers are WIDTH+1 wide so the sum's carry-out bit is
  // processed as an ordinary ninth bit against a zero-extended A.
  logic [WIDTH:0]   sum_sr;
  logic [WIDTH:0]   a_sr;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic x;
  logic y;
  logic d;
  logic borrow_next;
  logic last_bit;

  // One full-subtractor slice working on the current LSBs.
  assign x           = sum_sr[0];
  assign y           = a_sr[0];
  assign d           = x ^ y ^ borrow;
  assign borrow_next = (~x & y) | (~x & borrow) | (y & borrow);
  assign last_bit    = (cnt == CNT_W'(WIDTH));

  // The input side is only open in IDLE and is held closed during reset.
  assign in_ready = rst_n & (state == IDLE);
  assign busy     = (state == RUN) | (state == DONE);

`ifdef SUM_DEC_ERR_EN
  logic err_q;
  assign out_err = err_q;

  // Error flag: a final borrow means sum < A, and a set top difference bit
  // means the difference does not fit in WIDTH bits. The top difference
  // bit is the one produced on the last cycle, so it is taken straight
  // from the slice rather than stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == RUN && last_bit) begin
      err_q <= borrow_next | d;
    end else if (state == DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end
`else
  assign out_err = 1'b0;
`endif

  // Control FSM and datapath: load in IDLE, shift one bit per cycle in
  // RUN, hold the registered result in DONE until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_sr    <= '0;
      a_sr      <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sum_sr <= in_sum;
            a_sr   <= {1'b0, in_a};
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_sr <= {1'b0, sum_sr[WIDTH:1]};
          a_sr   <= {1'b0, a_sr[WIDTH:1]};
          borrow <= borrow_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            out_b     <= diff;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            diff <= {d, diff[WIDTH-1:1]};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_decoder.sv
// tb_sum_decoder: directed cases plus a randomized regression for
// sum_decoder, checked against a plain-arithmetic model of B = sum - A.
module tb_sum_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_sum;
  logic [7:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_b;
  logic       out_err;
  logic       busy;

  int assertCount;
  int failCount;

  sum_decoder #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_b    (out_b),
    .out_err  (out_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: B is the modulo-256 difference; the error flag marks
  // sums that no 8-bit B could have produced.
  function automatic logic [7:0] modelB(input logic [8:0] s, input logic [7:0] a);
    int diffVal;
    diffVal = int'(s) - int'(a);
    return 8'(diffVal & 255);
  endfunction

  function automatic logic modelErr(input logic [8:0] s, input logic [7:0] a);
`ifdef SUM_DEC_ERR_EN
    int diffVal;
    diffVal = int'(s) - int'(a);
    return (diffVal < 0) || (diffVal > 255);
`else
    return 1'b0 && (s != 9'(a));
`endif
  endfunction

  // One full transaction, driven and sampled on falling edges: optional
  // idle gap, accept, latency check, optional backpressure, handshake.
  task automatic applyStimulus(input logic [8:0] s, input logic [7:0] a,
                               input logic [7:0] expB, input logic expErr,
                               input int gap, input int hold);
    int waitCnt;
    int lat;
    for (int i = 0; i < gap; i++) @(negedge clk);
    in_sum   = s;
    in_a     = a;
    in_valid = 1'b1;
    waitCnt  = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = 9'($urandom);
    in_a     = 8'($urandom);
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!out_valid && lat < 9) begin
        in_valid = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'd9);
    checkOutput("out_b", 32'(out_b), 32'(expB));
    checkOutput("out_err", 32'(out_err), 32'(expErr));
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_b", 32'(out_b), 32'(expB));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] rs;
    int         seenValid;
    logic       errFlag;

    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sum      = '0;
    in_a        = '0;
    out_ready   = 1'b0;
`ifdef SUM_DEC_ERR_EN
    errFlag = 1'b1;
`else
    errFlag = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_b", 32'(out_b), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    applyStimulus(9'h0FF, 8'h7F, 8'h80, 1'b0, 0, 0);
    applyStimulus(9'h1FE, 8'hFF, 8'hFF, 1'b0, 0, 0);
    applyStimulus(9'h000, 8'h00, 8'h00, 1'b0, 0, 0);
    applyStimulus(9'h005, 8'h06, 8'hFF, errFlag, 0, 0);
    applyStimulus(9'h1FF, 8'h00, 8'hFF, errFlag, 0, 0);
    applyStimulus(9'h123, 8'h45, 8'hDE, 1'b0, 1, 5);

    // Reset during RUN cycle 4 discards the operation
    in_sum   = 9'h0AA;
    in_a     = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_rel_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rel_out_b", 32'(out_b), 32'd0);
    seenValid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seenValid++;
      @(negedge clk);
    end
    checkOutput("midrst_no_valid", 32'(seenValid), 32'd0);

    // Randomized regression: sum formed from a chosen B, B must come back
    for (int n = 0; n < 2000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 9'(ra) + 9'(rb);
      checkOutput("model_b", 32'(modelB(rs, ra)), 32'(rb));
      applyStimulus(rs, ra, rb, modelErr(rs, ra),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
